// File: rtl/cards_pkg.sv
// Shared card definitions: deck geometry, card code type and the shuffler state encoding.
// Suit/rank helpers decode a card code 0..DECK_SIZE-1 as suit=card/13, rank=card%13.
package cards_pkg;

  localparam int DECK_SIZE = 52;
  localparam int RANKS     = 13;
  localparam int SUITS     = 4;
  localparam int IDX_W     = 6;

  typedef logic [IDX_W-1:0] card_t;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SHUFFLE,
    READY
  } state_t;

  function automatic logic [1:0] card_suit(input card_t c);
    return 2'(c / card_t'(RANKS));
  endfunction

  function automatic logic [3:0] card_rank(input card_t c);
    return 4'(c % card_t'(RANKS));
  endfunction

endpackage

// File: rtl/deck_shuffler.sv
// Fisher-Yates deck shuffler with rejection sampling; INIT takes DECK_SIZE cycles, SHUFFLE >= DECK_SIZE-1.
// Deals one card per accepted deal_req, card_valid one cycle later; rnd_in samples above i stall the shuffle.
module deck_shuffler #(
  parameter int DECK_SIZE = cards_pkg::DECK_SIZE,
  parameter int IDX_W     = cards_pkg::IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] rnd_in,
  output logic             busy,
  output logic             ready,
  input  logic             deal_req,
  output logic             card_valid,
  output logic [IDX_W-1:0] card_out,
  output logic [IDX_W-1:0] cards_left,
  output logic             deck_empty
);

  import cards_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);
  localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(DECK_SIZE);

  state_t state_q, state_d;

  // idx is k while filling the deck and i while shuffling
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cards_left_q, cards_left_d;
  logic [IDX_W-1:0] card_out_q, card_out_d;
  logic             card_valid_q, card_valid_d;
  logic [IDX_W-1:0] deck_q [DECK_SIZE];
  logic [IDX_W-1:0] deck_d [DECK_SIZE];

  logic accept_j;
  logic deal_ok;

  always_comb begin
    accept_j = (rnd_in <= idx_q);
    deal_ok  = (state_q == READY) && deal_req && !start && (cards_left_q != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    if (idx_q == LAST_IDX) state_d = SHUFFLE;
      SHUFFLE: if (accept_j && (idx_q == IDX_W'(1))) state_d = READY;
      READY:   if (start) state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == INIT) || (state_q == SHUFFLE);
    ready      = (state_q == READY);
    deck_empty = (state_q == READY) && (cards_left_q == '0);
  end

  always_comb begin
    idx_d        = idx_q;
    ptr_d        = ptr_q;
    cards_left_d = cards_left_q;
    card_out_d   = card_out_q;
    card_valid_d = 1'b0;
    deck_d       = deck_q;
    case (state_q)
      IDLE: begin
        if (start) idx_d = '0;
      end
      INIT: begin
        deck_d[idx_q] = idx_q;
        idx_d = (idx_q == LAST_IDX) ? LAST_IDX : idx_q + IDX_W'(1);
      end
      SHUFFLE: begin
        // j == i writes the same entry twice with its own value, a legal no-op
        if (accept_j) begin
          deck_d[idx_q]  = deck_q[rnd_in];
          deck_d[rnd_in] = deck_q[idx_q];
          idx_d = idx_q - IDX_W'(1);
          if (idx_q == IDX_W'(1)) begin
            cards_left_d = FULL_CNT;
            ptr_d        = '0;
          end
        end
      end
      READY: begin
        if (start) begin
          idx_d        = '0;
          ptr_d        = '0;
          cards_left_d = '0;
        end else if (deal_ok) begin
          card_out_d   = deck_q[ptr_q];
          card_valid_d = 1'b1;
          ptr_d        = ptr_q + IDX_W'(1);
          cards_left_d = cards_left_q - IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      ptr_q        <= '0;
      cards_left_q <= '0;
      card_out_q   <= '0;
      card_valid_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      ptr_q        <= ptr_d;
      cards_left_q <= cards_left_d;
      card_out_q   <= card_out_d;
      card_valid_q <= card_valid_d;
    end
  end

  // Deck contents are meaningless after reset until INIT refills them
  always_ff @(posedge clock) begin
    deck_q <= deck_d;
  end

  assign card_valid = card_valid_q;
  assign card_out   = card_out_q;
  assign cards_left = cards_left_q;

endmodule
